// File: rtl/accel_pkg.sv
// Shared definitions for the accelerator bus: accel ids, keyboard event codes,
// event word layout and command bits.
package accel_pkg;

  localparam logic [2:0] ACCEL_ID_SWAP     = 3'd0;
  localparam logic [2:0] ACCEL_ID_LINE     = 3'd1;
  localparam logic [2:0] ACCEL_ID_FILL     = 3'd2;
  localparam logic [2:0] ACCEL_ID_SYMBOL   = 3'd3;
  localparam logic [2:0] ACCEL_ID_KEYBOARD = 3'd4;

  typedef enum logic [1:0] {
    KEY_EVT_SYMBOL    = 2'd0,
    KEY_EVT_LEFT      = 2'd1,
    KEY_EVT_RIGHT     = 2'd2,
    KEY_EVT_BACKSPACE = 2'd3
  } key_evt_e;

  localparam int ACCEL_WORD_W  = 16;
  localparam int EVT_TYPE_MSB  = 15;
  localparam int EVT_TYPE_LSB  = 14;
  localparam int EVT_OVF_BIT   = 13;
  localparam int EVT_PAYLOAD_W = 13;
  localparam int CMD_CLEAR_BIT = 0;

  function automatic logic [ACCEL_WORD_W-1:0] pack_event_word(
    input key_evt_e                 evt_type,
    input logic                     overflow,
    input logic [EVT_PAYLOAD_W-1:0] payload
  );
    return {evt_type, overflow, payload};
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Register-array FIFO with show-ahead read; clear dominates push/pop, and a push
// into a full FIFO is accepted when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     clear,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [AW-1:0]    wr_ptr_reg, wr_ptr_next;
  logic [AW-1:0]    rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0]    count_reg, count_next;
  logic             pop_ok;
  logic             push_ok;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == CW'(DEPTH));
  assign count   = count_reg;
  assign rd_data = mem_reg[rd_ptr_reg];

  assign pop_ok  = pop && !empty && !clear;
  assign push_ok = push && !clear && (!full || pop_ok);

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (clear) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      count_next  = '0;
    end else begin
      // Pointer widths equal log2(DEPTH), so natural overflow is the wrap.
      if (push_ok) wr_ptr_next = wr_ptr_reg + AW'(1);
      if (pop_ok)  rd_ptr_next = rd_ptr_reg + AW'(1);
      count_next = count_reg + CW'(push_ok) - CW'(pop_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push_ok) mem_reg[wr_ptr_reg] <= wr_data;
  end

endmodule

// File: rtl/keyboard_accel_adapter.sv
// Keyboard responder on the accelerator bus: prioritises key strobes into one
// event per cycle, queues them, and serves them to the CPU with a sticky overflow flag.
module keyboard_accel_adapter
  import accel_pkg::*;
#(
  parameter int SYMBOL_WIDTH = 7,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    keyboard_left,
  input  logic                    keyboard_right,
  input  logic                    keyboard_backspace,
  input  logic [SYMBOL_WIDTH-1:0] keyboard_symbol,
  output logic                    accel_can_read,
  output logic                    accel_can_write,
  input  logic                    accel_read_enable,
  input  logic                    accel_write_enable,
  output logic [15:0]             accel_read_data,
  input  logic [15:0]             accel_write_data
);

  localparam int STORE_W = 2 + SYMBOL_WIDTH;
  localparam int CW      = $clog2(FIFO_DEPTH) + 1;

  key_evt_e                evt_type;
  logic [SYMBOL_WIDTH-1:0] evt_sym;
  logic                    evt_valid;
  logic                    clear_cmd;

  logic [STORE_W-1:0]      head_word;
  key_evt_e                head_type;
  logic [SYMBOL_WIDTH-1:0] head_sym;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic [CW-1:0]           fifo_count;

  logic                    overflow_reg, overflow_next;
  logic                    can_write_reg;

  always_comb begin
    evt_valid = 1'b1;
    evt_type  = KEY_EVT_SYMBOL;
    evt_sym   = '0;
    if (keyboard_backspace) begin
      evt_type = KEY_EVT_BACKSPACE;
    end else if (keyboard_left) begin
      evt_type = KEY_EVT_LEFT;
    end else if (keyboard_right) begin
      evt_type = KEY_EVT_RIGHT;
    end else if (keyboard_symbol != '0) begin
      evt_sym = keyboard_symbol;
    end else begin
      evt_valid = 1'b0;
    end
  end

  assign clear_cmd = accel_write_enable && accel_write_data[CMD_CLEAR_BIT];

  sync_fifo #(
    .WIDTH (STORE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_event_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (evt_valid),
    .pop     (accel_read_enable),
    .clear   (clear_cmd),
    .wr_data ({evt_type, evt_sym}),
    .rd_data (head_word),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // A full FIFO is never empty, so a read request here is always a real pop.
  always_comb begin
    overflow_next = overflow_reg;
    if (clear_cmd) begin
      overflow_next = 1'b0;
    end else if (evt_valid && fifo_full && !accel_read_enable) begin
      overflow_next = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_reg  <= 1'b0;
      can_write_reg <= 1'b0;
    end else begin
      overflow_reg  <= overflow_next;
      can_write_reg <= 1'b1;
    end
  end

  assign head_type = key_evt_e'(head_word[STORE_W-1 -: 2]);
  assign head_sym  = head_word[SYMBOL_WIDTH-1:0];

  // Overflow is merged at read time so every queued entry shows the live flag.
  assign accel_read_data = fifo_empty ? '0
                         : pack_event_word(head_type, overflow_reg,
                                           EVT_PAYLOAD_W'(head_sym));
  assign accel_can_read  = !fifo_empty;
  assign accel_can_write = can_write_reg;

  logic unused_inputs;
  assign unused_inputs = ^{accel_write_data[15:1], fifo_count};

endmodule

// File: tb/tb_keyboard_accel_adapter.sv
// Self-checking bench: directed scenarios plus random traffic compared each cycle
// against a queue-based model of the keyboard event adapter.
module tb_keyboard_accel_adapter;

  logic        clk = 1'b0;
  logic        rst;
  logic        keyboard_left, keyboard_right, keyboard_backspace;
  logic [6:0]  keyboard_symbol;
  logic        accel_can_read, accel_can_write;
  logic        accel_read_enable, accel_write_enable;
  logic [15:0] accel_read_data, accel_write_data;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [1:0] t;
    logic [6:0] s;
  } ev_t;

  ev_t  mq[$];
  logic m_ovf;
  logic m_cw;

  always #5 clk = ~clk;

  keyboard_accel_adapter #(.SYMBOL_WIDTH(7), .FIFO_DEPTH(8)) dut (
    .clk                (clk),
    .rst                (rst),
    .keyboard_left      (keyboard_left),
    .keyboard_right     (keyboard_right),
    .keyboard_backspace (keyboard_backspace),
    .keyboard_symbol    (keyboard_symbol),
    .accel_can_read     (accel_can_read),
    .accel_can_write    (accel_can_write),
    .accel_read_enable  (accel_read_enable),
    .accel_write_enable (accel_write_enable),
    .accel_read_data    (accel_read_data),
    .accel_write_data   (accel_write_data)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] model_word();
    if (mq.size() == 0) return 16'h0000;
    return {mq[0].t, m_ovf, 6'b0, mq[0].s};
  endfunction

  task automatic model_step(input logic r, input logic l, input logic rt, input logic bs,
                            input logic [6:0] s, input logic re, input logic we,
                            input logic [15:0] wd);
    ev_t ev;
    bit  has_ev;
    if (r) begin
      mq.delete();
      m_ovf = 1'b0;
      m_cw  = 1'b0;
      return;
    end
    m_cw = 1'b1;
    if (we && wd[0]) begin
      mq.delete();
      m_ovf = 1'b0;
      return;
    end
    has_ev = 1'b1;
    if (bs)          ev = '{t: 2'd3, s: 7'd0};
    else if (l)      ev = '{t: 2'd1, s: 7'd0};
    else if (rt)     ev = '{t: 2'd2, s: 7'd0};
    else if (s != 0) ev = '{t: 2'd0, s: s};
    else begin
      has_ev = 1'b0;
      ev = '0;
    end
    if (re && mq.size() > 0) void'(mq.pop_front());
    if (has_ev) begin
      if (mq.size() < 8) mq.push_back(ev);
      else m_ovf = 1'b1;
    end
  endtask

  // One clock: drive inputs, let the edge happen, update the model, compare.
  task automatic cyc(input logic r, input logic l, input logic rt, input logic bs,
                     input logic [6:0] s, input logic re, input logic we,
                     input logic [15:0] wd);
    rst = r; keyboard_left = l; keyboard_right = rt; keyboard_backspace = bs;
    keyboard_symbol = s; accel_read_enable = re; accel_write_enable = we;
    accel_write_data = wd;
    @(posedge clk);
    model_step(r, l, rt, bs, s, re, we, wd);
    #1;
    rst = 1'b0; keyboard_left = 1'b0; keyboard_right = 1'b0; keyboard_backspace = 1'b0;
    keyboard_symbol = '0; accel_read_enable = 1'b0; accel_write_enable = 1'b0;
    accel_write_data = '0;
    check("can_read",  {15'd0, accel_can_read},  {15'd0, (mq.size() > 0)});
    check("can_write", {15'd0, accel_can_write}, {15'd0, m_cw});
    check("read_data", accel_read_data, model_word());
  endtask

  task automatic idle();         cyc(0, 0, 0, 0, 7'd0, 0, 0, 16'h0); endtask
  task automatic sym(input logic [6:0] s); cyc(0, 0, 0, 0, s, 0, 0, 16'h0); endtask
  task automatic pop();          cyc(0, 0, 0, 0, 7'd0, 1, 0, 16'h0); endtask
  task automatic clr();          cyc(0, 0, 0, 0, 7'd0, 0, 1, 16'h0001); endtask

  initial begin
    logic [15:0] exp_word;
    m_ovf = 1'b0;
    m_cw  = 1'b0;

    // 1. reset then idle
    cyc(1, 0, 0, 0, 7'd0, 0, 0, 16'h0);
    check("rst_can_write", {15'd0, accel_can_write}, 16'h0000);
    cyc(1, 0, 0, 0, 7'd0, 0, 0, 16'h0);
    idle();
    check("idle_can_read",  {15'd0, accel_can_read},  16'h0000);
    check("idle_can_write", {15'd0, accel_can_write}, 16'h0001);
    check("idle_data",      accel_read_data,          16'h0000);

    // 2. single symbol
    sym(7'h41);
    check("sym41_can_read", {15'd0, accel_can_read}, 16'h0001);
    check("sym41_data",     accel_read_data,         16'h0041);
    pop();
    check("sym41_popped",   {15'd0, accel_can_read}, 16'h0000);

    // 3. left + backspace together: backspace only
    cyc(0, 1, 0, 1, 7'd0, 0, 0, 16'h0);
    check("prio_data", accel_read_data, 16'hC000);
    pop();
    check("prio_single", {15'd0, accel_can_read}, 16'h0000);

    // 4. overflow on the ninth symbol
    for (int i = 1; i <= 9; i++) sym(7'(i));
    for (int i = 1; i <= 8; i++) begin
      exp_word = 16'h2000 + 16'(i);
      check("ovf_entry", accel_read_data, exp_word);
      pop();
    end
    check("ovf_drained", {15'd0, accel_can_read}, 16'h0000);

    // 5. full, push and pop together
    clr();
    for (int i = 0; i < 8; i++) sym(7'h11 + 7'(i));
    cyc(0, 0, 0, 0, 7'h19, 1, 0, 16'h0);
    for (int i = 0; i < 8; i++) begin
      exp_word = 16'h0012 + 16'(i);
      check("fullpp_entry", accel_read_data, exp_word);
      pop();
    end
    check("fullpp_drained", {15'd0, accel_can_read}, 16'h0000);

    // 6. clear and reset with same-cycle strobe; bit0=0 write is a no-op
    sym(7'h01); sym(7'h02); sym(7'h03);
    cyc(0, 0, 0, 0, 7'd0, 0, 1, 16'hFFFE);
    check("noop_write", accel_read_data, 16'h0001);
    cyc(0, 0, 0, 0, 7'h33, 0, 1, 16'h0001);
    check("clear_can_read", {15'd0, accel_can_read}, 16'h0000);
    sym(7'h05);
    check("clear_no_ovf", accel_read_data, 16'h0005);
    sym(7'h01); sym(7'h02);
    cyc(1, 0, 0, 0, 7'h33, 1, 1, 16'h0001);
    check("rst_can_read", {15'd0, accel_can_read}, 16'h0000);
    sym(7'h06);
    check("rst_no_ovf", accel_read_data, 16'h0006);

    // random traffic
    for (int n = 0; n < 600; n++) begin
      logic       r, l, rt, bs, re, we;
      logic [6:0] s;
      logic [15:0] wd;
      r  = ($urandom_range(0, 199) == 0);
      l  = ($urandom_range(0, 5) == 0);
      rt = ($urandom_range(0, 5) == 0);
      bs = ($urandom_range(0, 7) == 0);
      s  = ($urandom_range(0, 1) == 0) ? 7'd0 : 7'($urandom_range(0, 127));
      re = ($urandom_range(0, 2) == 0);
      we = ($urandom_range(0, 29) == 0);
      wd = 16'($urandom);
      cyc(r, l, rt, bs, s, re, we, wd);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
